// File: rtl/wsa_pkg.sv
// ---------------------------------------------------------------------------
// wsa_pkg
// Shared definitions for the weight SRAM arbiter:
//   - WSA_ADDR_W_DEFAULT : default SRAM half-word address width
//   - wsa_state_e        : arbiter FSM states
//   - wsa_strobe_t       : bundle of the three active-low SRAM strobes
//   - STROBE_*           : strobe patterns driven in each phase of an access
// ---------------------------------------------------------------------------
package wsa_pkg;

  localparam int unsigned WSA_ADDR_W_DEFAULT = 20;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_LO    = 3'd1,
    ST_RD_HI    = 3'd2,
    ST_RD_DONE  = 3'd3,
    ST_WR_SETUP = 3'd4,
    ST_WR_PULSE = 3'd5,
    ST_WR_DONE  = 3'd6
  } wsa_state_e;

  typedef struct packed {
    logic ce_n;
    logic oe_n;
    logic we_n;
  } wsa_strobe_t;

  // All strobes released: the SRAM is deselected.
  localparam wsa_strobe_t STROBE_IDLE     = '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1};
  // Chip selected with output enabled for both read halves.
  localparam wsa_strobe_t STROBE_READ     = '{ce_n: 1'b0, oe_n: 1'b1 ^ 1'b1, we_n: 1'b1};
  // Chip selected, address/data stable around the write pulse.
  localparam wsa_strobe_t STROBE_WR_HOLD  = '{ce_n: 1'b0, oe_n: 1'b1, we_n: 1'b1};
  // The write pulse itself.
  localparam wsa_strobe_t STROBE_WR_PULSE = '{ce_n: 1'b0, oe_n: 1'b1, we_n: 1'b0};

endpackage : wsa_pkg

// File: rtl/wsa_starve_ctr.sv
// ---------------------------------------------------------------------------
// wsa_starve_ctr
// Counts read grants issued while a write is pending. Once the count
// saturates at STARVE_MAX, force_wr_o tells the arbiter to give the next
// IDLE slot to the write even if a read is also requested.
// Ports:
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   rd_grant_i     : a read was granted this cycle
//   wr_grant_i     : a write was granted this cycle
//   wr_req_i       : loader write request level
//   force_wr_o     : counter has reached STARVE_MAX
// ---------------------------------------------------------------------------
module wsa_starve_ctr #(
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic rd_grant_i,
  input  logic wr_grant_i,
  input  logic wr_req_i,
  output logic force_wr_o
);

  localparam int unsigned CNT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] cnt_q;

  // A write that is granted, or that is no longer waiting, owes nothing.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (wr_grant_i || !wr_req_i) begin
      cnt_q <= '0;
    end else if (rd_grant_i && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign force_wr_o = (cnt_q == CNT_MAX);

endmodule : wsa_starve_ctr

// File: rtl/weight_sram_arbiter.sv
// ---------------------------------------------------------------------------
// weight_sram_arbiter
// Shares one 16-bit SRAM port between 32-bit inference reads (two half-word
// accesses, even address first) and 16-bit loader writes. Every access runs
// to completion; outputs are registered or decoded from state only.
//
// Optional feature macro: WSA_STARVE_GUARD_EN
//   defined   : after STARVE_MAX read grants with a write pending, the write
//               wins the next IDLE slot.
//   undefined : strict read priority; a write is granted only when no read
//               is requested.
//
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   rd_req_i, rd_word_i            read request and 32-bit word index
//   rd_valid_o, rd_data_o          read completion pulse and assembled word
//   wr_req_i, wr_addr_i, wr_data_i write request, half-word address, data
//   wr_ack_o                       write completion pulse
//   sram_addr_o, sram_wdata_o      SRAM address and write data
//   sram_rdata_i                   SRAM read data
//   sram_ce_n_o/oe_n_o/we_n_o      active-low SRAM strobes
//   busy_o                         high whenever the FSM is not IDLE
// ---------------------------------------------------------------------------
module weight_sram_arbiter
  import wsa_pkg::*;
#(
  parameter int unsigned ADDR_W    = WSA_ADDR_W_DEFAULT,
  parameter int unsigned READ_WAIT = 2
`ifdef WSA_STARVE_GUARD_EN
  ,
  parameter int unsigned STARVE_MAX = 8
`endif
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              rd_req_i,
  input  logic [ADDR_W-2:0] rd_word_i,
  output logic              rd_valid_o,
  output logic [31:0]       rd_data_o,
  input  logic              wr_req_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [15:0]       wr_data_i,
  output logic              wr_ack_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [15:0]       sram_wdata_o,
  input  logic [15:0]       sram_rdata_i,
  output logic              sram_ce_n_o,
  output logic              sram_oe_n_o,
  output logic              sram_we_n_o,
  output logic              busy_o
);

  localparam int unsigned WAIT_W = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(READ_WAIT - 1);

  wsa_state_e        state_q;
  logic [WAIT_W-1:0] wait_q;
  logic [15:0]       lo_half_q;
  logic [31:0]       rd_data_q;
  logic              rd_valid_q;
  logic              wr_ack_q;
  logic [ADDR_W-1:0] sram_addr_q;
  logic [15:0]       sram_wdata_q;
  wsa_strobe_t       strobe_q;

  logic is_idle;
  logic wait_last;
  logic force_wr;
  logic rd_grant;
  logic wr_grant;

  assign is_idle   = (state_q == ST_IDLE);
  assign wait_last = (wait_q == WAIT_LAST);

  // Grants only happen in IDLE. Reads win unless the write has been starved.
  assign rd_grant = is_idle && rd_req_i && !(wr_req_i && force_wr);
  assign wr_grant = is_idle && wr_req_i && !rd_grant;

`ifdef WSA_STARVE_GUARD_EN
  wsa_starve_ctr #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve_ctr (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .rd_grant_i (rd_grant),
    .wr_grant_i (wr_grant),
    .wr_req_i   (wr_req_i),
    .force_wr_o (force_wr)
  );
`else
  assign force_wr = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      wait_q       <= '0;
      lo_half_q    <= '0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      wr_ack_q     <= 1'b0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
      strobe_q     <= STROBE_IDLE;
    end else begin
      rd_valid_q <= 1'b0;
      wr_ack_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // The address/data registers double as the latched request, so
          // later changes on the request inputs have no effect.
          if (rd_grant) begin
            state_q     <= ST_RD_LO;
            wait_q      <= '0;
            sram_addr_q <= {rd_word_i, 1'b0};
            strobe_q    <= STROBE_READ;
          end else if (wr_grant) begin
            state_q      <= ST_WR_SETUP;
            sram_addr_q  <= wr_addr_i;
            sram_wdata_q <= wr_data_i;
            strobe_q     <= STROBE_WR_HOLD;
          end
        end
        ST_RD_LO: begin
          if (wait_last) begin
            // Low half is parked so rd_data_o only changes on completion.
            lo_half_q      <= sram_rdata_i;
            sram_addr_q[0] <= 1'b1;
            wait_q         <= '0;
            state_q        <= ST_RD_HI;
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
          end
        end
        ST_RD_HI: begin
          if (wait_last) begin
            rd_data_q  <= {sram_rdata_i, lo_half_q};
            rd_valid_q <= 1'b1;
            wait_q     <= '0;
            strobe_q   <= STROBE_IDLE;
            state_q    <= ST_RD_DONE;
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
          end
        end
        ST_RD_DONE: begin
          state_q <= ST_IDLE;
        end
        ST_WR_SETUP: begin
          strobe_q <= STROBE_WR_PULSE;
          state_q  <= ST_WR_PULSE;
        end
        ST_WR_PULSE: begin
          strobe_q <= STROBE_WR_HOLD;
          wr_ack_q <= 1'b1;
          state_q  <= ST_WR_DONE;
        end
        ST_WR_DONE: begin
          strobe_q <= STROBE_IDLE;
          state_q  <= ST_IDLE;
        end
        default: begin
          strobe_q <= STROBE_IDLE;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

  assign rd_valid_o   = rd_valid_q;
  assign rd_data_o    = rd_data_q;
  assign wr_ack_o     = wr_ack_q;
  assign sram_addr_o  = sram_addr_q;
  assign sram_wdata_o = sram_wdata_q;
  assign sram_ce_n_o  = strobe_q.ce_n;
  assign sram_oe_n_o  = strobe_q.oe_n;
  assign sram_we_n_o  = strobe_q.we_n;
  assign busy_o       = !is_idle;

endmodule : weight_sram_arbiter

// File: tb/tb_weight_sram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_weight_sram_arbiter
// Directed bench for weight_sram_arbiter with a transaction-level reference
// model (cycle offset since grant) and a behavioural SRAM. Honours
// WSA_STARVE_GUARD_EN in the same way as the design.
// ---------------------------------------------------------------------------
module tb_weight_sram_arbiter;

  localparam int ADDR_W  = 20;
  localparam int RW      = 2;
  localparam int LAST_RD = 2 * RW + 1;
`ifdef WSA_STARVE_GUARD_EN
  localparam int SMAX    = 8;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              rd_req;
  logic [ADDR_W-2:0] rd_word;
  logic              rd_valid;
  logic [31:0]       rd_data;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;
  logic              wr_ack;
  logic [ADDR_W-1:0] sram_addr;
  logic [15:0]       sram_wdata;
  logic [15:0]       sram_rdata;
  logic              sram_ce_n, sram_oe_n, sram_we_n;
  logic              busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  weight_sram_arbiter dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .rd_req_i     (rd_req),
    .rd_word_i    (rd_word),
    .rd_valid_o   (rd_valid),
    .rd_data_o    (rd_data),
    .wr_req_i     (wr_req),
    .wr_addr_i    (wr_addr),
    .wr_data_i    (wr_data),
    .wr_ack_o     (wr_ack),
    .sram_addr_o  (sram_addr),
    .sram_wdata_o (sram_wdata),
    .sram_rdata_i (sram_rdata),
    .sram_ce_n_o  (sram_ce_n),
    .sram_oe_n_o  (sram_oe_n),
    .sram_we_n_o  (sram_we_n),
    .busy_o       (busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural SRAM ----------------
  // Unwritten locations return a pattern derived from the address.
  bit [15:0] mem [int];
  int        mem_gen = 0;

  function automatic logic [15:0] mem_rd(input logic [ADDR_W-1:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    return a[15:0] ^ 16'hA5A5;
  endfunction

  always @(sram_addr or sram_ce_n or sram_oe_n or mem_gen)
    sram_rdata = (!sram_ce_n && !sram_oe_n) ? mem_rd(sram_addr) : 16'hDEAD;

  always @(posedge clk) begin
    if (!sram_ce_n && !sram_we_n) begin
      mem[int'(sram_addr)] = sram_wdata;
      mem_gen++;
    end
  end

  // ---------------- reference model ----------------
  // kind: 0 idle, 1 read, 2 write; k: cycles since the grant cycle.
  int                m_kind, m_k, m_starve;
  logic [ADDR_W-1:0] m_addr;
  logic [15:0]       m_wdata;
  logic [31:0]       m_pend, m_rd_held;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_kind = 0; m_k = 0; m_starve = 0;
      m_addr = '0; m_wdata = '0; m_pend = '0; m_rd_held = '0;
    end else begin
      bit gr_rd, gr_wr, force_w;
      gr_rd = 1'b0; gr_wr = 1'b0; force_w = 1'b0;
      if (m_kind == 0) begin
`ifdef WSA_STARVE_GUARD_EN
        force_w = (m_starve >= SMAX);
`endif
        if (rd_req && !(wr_req && force_w)) gr_rd = 1'b1;
        else if (wr_req) gr_wr = 1'b1;
      end
`ifdef WSA_STARVE_GUARD_EN
      if (gr_wr || !wr_req) m_starve = 0;
      else if (gr_rd && m_starve < SMAX) m_starve = m_starve + 1;
`endif
      if (gr_rd) begin
        m_kind = 1; m_k = 1;
        m_addr = {rd_word, 1'b0};
        m_pend = {mem_rd({rd_word, 1'b1}), mem_rd({rd_word, 1'b0})};
      end else if (gr_wr) begin
        m_kind = 2; m_k = 1;
        m_addr = wr_addr; m_wdata = wr_data;
      end else if (m_kind != 0) begin
        m_k = m_k + 1;
        if (m_kind == 1 && m_k == RW + 1) m_addr[0] = 1'b1;
        if (m_kind == 1 && m_k == LAST_RD) m_rd_held = m_pend;
        if ((m_kind == 1 && m_k > LAST_RD) || (m_kind == 2 && m_k > 3)) m_kind = 0;
      end
    end
  end

  // Event log: 0 = read completion, 1 = write completion.
  bit ev_q[$];
  int wr_ack_cnt = 0;

  always @(negedge clk) begin
    logic e_ce, e_oe, e_we;
    e_ce = !(m_kind == 2 || (m_kind == 1 && m_k <= 2 * RW));
    e_oe = !(m_kind == 1 && m_k <= 2 * RW);
    e_we = !(m_kind == 2 && m_k == 2);
    chk("m_ce_n",   sram_ce_n,  e_ce);
    chk("m_oe_n",   sram_oe_n,  e_oe);
    chk("m_we_n",   sram_we_n,  e_we);
    chk("m_busy",   busy,       m_kind != 0);
    chk("m_rdval",  rd_valid,   m_kind == 1 && m_k == LAST_RD);
    chk("m_wrack",  wr_ack,     m_kind == 2 && m_k == 3);
    chk("m_addr",   sram_addr,  m_addr);
    chk("m_wdata",  sram_wdata, m_wdata);
    chk("m_rddata", rd_data,    m_rd_held);
    if (rd_valid) ev_q.push_back(1'b0);
    if (wr_ack) begin
      ev_q.push_back(1'b1);
      wr_ack_cnt++;
    end
  end

  // ---------------- directed helpers ----------------
  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", busy, 1'b0);
  endtask

  task automatic do_read(input logic [ADDR_W-2:0] word, input logic [31:0] expd, input int drop_c);
    @(negedge clk);
    rd_word = word;
    rd_req  = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) rd_word = ~word;  // must be ignored after grant
      if (c == drop_c) rd_req = 1'b0;
      chk("rd_valid_cycle", rd_valid, c == 5);
      if (c <= 2) chk("rd_addr_lo", sram_addr, {word, 1'b0});
      else if (c <= 4) chk("rd_addr_hi", sram_addr, {word, 1'b1});
      if (c == 5) chk("rd_data", rd_data, expd);
    end
    rd_req = 1'b0;
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [15:0] d);
    @(negedge clk);
    wr_addr = a;
    wr_data = d;
    wr_req  = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) wr_data = ~d;  // must be ignored after grant
      chk("wr_we_n_cycle", sram_we_n, c != 2);
      chk("wr_ack_cycle", wr_ack, c == 3);
      if (c == 3) wr_req = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int quiet, nr, nw, ack0;
    rst_n = 1'b0; rd_req = 1'b0; rd_word = '0;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset values and a quiet idle period.
    @(negedge clk);
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_rd_data", rd_data, 32'h0);
    chk("rst_wr_ack", wr_ack, 1'b0);
    chk("rst_addr", sram_addr, 20'h0);
    chk("rst_wdata", sram_wdata, 16'h0);
    chk("rst_strobes", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b111);
    chk("rst_busy", busy, 1'b0);
    quiet = 0;
    repeat (20) begin
      @(negedge clk);
      if (!sram_ce_n || !sram_oe_n || !sram_we_n || busy) quiet++;
    end
    chk("idle_quiet", quiet, 0);

    // Single read from a preloaded location.
    mem[32'h10] = 16'h1456;
    mem[32'h11] = 16'h3ff1;
    mem_gen++;
    do_read(19'd8, 32'h3ff11456, 5);
    wait_idle();

    // Single write, then read it back with its unwritten odd neighbour.
    do_write(20'h00abc, 16'hbeef);
    wait_idle();
    chk("wr_mem", mem_rd(20'h00abc), 16'hbeef);
    do_read(19'h0055e, 32'haf18beef, 5);
    wait_idle();

    // Requester drops rd_req in cycle 2; the read still completes.
    do_read(19'h00021, 32'ha5e6a5e7, 2);
    wait_idle();

    // Both requesters held continuously.
    @(negedge clk);
    ev_q.delete();
    rd_word = 19'd3; wr_addr = 20'h00100; wr_data = 16'h1234;
    rd_req = 1'b1; wr_req = 1'b1;
    repeat (120) @(negedge clk);
    rd_req = 1'b0; wr_req = 1'b0;
    wait_idle();
    nr = 0; nw = 0;
    foreach (ev_q[i]) if (ev_q[i]) nw++; else nr++;
`ifdef WSA_STARVE_GUARD_EN
    chk("arb_event_count", ev_q.size(), 20);
    for (int i = 0; i < 18 && i < ev_q.size(); i++)
      chk("arb_order", ev_q[i], (i % 9) == 8);
`else
    chk("strict_writes", nw, 0);
    chk("strict_reads", nr, 20);
`endif

    // Reset asserted during the write pulse.
    ack0 = wr_ack_cnt;
    @(negedge clk);
    wr_addr = 20'h02222; wr_data = 16'h5555; wr_req = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #2;
    chk("rst_mid_pulse_before", sram_we_n, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_we_n", sram_we_n, 1'b1);
    chk("rst_mid_ce_n", sram_ce_n, 1'b1);
    chk("rst_mid_busy", busy, 1'b0);
    wr_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_mid_no_ack", wr_ack_cnt, ack0);
    chk("rst_mid_idle", busy, 1'b0);
    chk("rst_mid_mem", mem_rd(20'h02222), 16'h8787);

    // Normal operation resumes after the aborted access.
    do_write(20'h00010, 16'h0f0f);
    wait_idle();
    do_read(19'd8, 32'h3ff10f0f, 5);
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_weight_sram_arbiter
